demux_stream_router: RTL and testbench
======================================

# demux_stream_router

Buffered, flow-controlled 1-to-4 stream router. It accepts a single WIDTH-bit input stream, where each word carries a 2-bit destination tag. Each word is steered into one of four per-channel FIFOs, and each channel drains independently through its own valid/ready port. It is the sequential counterpart of the combinational 1-to-4 demux: the same steering function, but words are held until each consumer takes them, so no data is lost when a consumer stalls.

## Interface
Parameters:
- WIDTH, 8, data word width.
- DEPTH, 2, entries per channel FIFO; power of two, ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  WIDTH  input word.
- in_dest  input  2  destination channel for in_data (0..3).
- in_valid  input  1  in_data/in_dest valid.
- in_ready  output  1  router can accept the word addressed by in_dest.
- out_data0..out_data3  output  WIDTH each  head word of channel k; all-zero when out_valid[k]=0.
- out_valid  output  4  bit k: channel k FIFO non-empty.
- out_ready  input  4  bit k: consumer k takes head word.
- occupancy  output  4×($clog2(DEPTH)+1), packed {ch3,ch2,ch1,ch0}  entry count per channel.

Clock and reset are fixed: one clock; reset is synchronous and active-high.

## Operation
Each channel k has its own FIFO: DEPTH-entry storage, read/write pointers and count.

Input side:
- in_ready = !rst && (count[in_dest] != DEPTH). This is combinational from in_dest and channel state.
- The source holds in_data/in_dest stable while in_valid=1 and in_ready=0.
- Push rule: in_valid && in_ready at a rising edge writes in_data to FIFO[in_dest] and increments its write pointer.
- A full channel stalls only words addressed to it. A word for another channel is accepted normally.
- No pass-through when full. A full FIFO is not pushed in the same cycle as its pop, even though it frees a slot. in_ready reflects the count before the edge.

Output side, per channel, first-word-fall-through:
- out_valid[k] = (count[k] != 0).
- out_data_k = head entry when out_valid[k]=1, else {WIDTH{1'b0}}.
- Pop rule: out_valid[k] && out_ready[k] at an edge advances the read pointer.
- out_ready[k] with out_valid[k]=0 is ignored.

Count update per channel: +1 on push only, −1 on pop only, unchanged on simultaneous push+pop (possible only when 0 < count < DEPTH).

Pointers wrap modulo DEPTH. Count ranges 0..DEPTH and never exceeds DEPTH or underflows.

Channels are fully independent. The four pops and the one push may all occur in the same cycle.

Reset:
- Every count and pointer goes to 0.
- Outputs during and after rst: out_valid=4'b0000, out_data0..3=0, occupancy=0, in_ready=0 while rst=1.
- Reset mid-stream discards all buffered words.
- Storage contents need not be cleared; the zero output gating hides them.

## Timing
- Latency: a word accepted at edge N appears with out_valid[k]=1 in the cycle following edge N.
- Minimum in→out latency is 1 cycle; there is no combinational in→out path.
- Throughput: 1 word/cycle into the router. Each channel can sustain 1 word/cycle when its consumer holds out_ready=1.
- A freed slot raises in_ready in the cycle after the pop edge.
- in_ready is the only combinational output. out_valid, out_data and occupancy depend only on registered state.
- First cycle with rst=0: in_ready=1 for any in_dest.

## Test plan
- **Reset:** apply rst for 2 cycles with random inputs. Required: out_valid=0, out_data*=0, occupancy=0, in_ready=0; after release in_ready=1.
- **Steering:** push 0x11,0x22,0x33,0x44 with in_dest 0,1,2,3 on consecutive cycles, all out_ready=1. Required: out_data0=0x11 one cycle after its accept edge, and likewise 0x22 on ch1, 0x33 on ch2, 0x44 on ch3; no word appears on any other channel.
- **Full/backpressure:** with DEPTH=2 and out_ready[0]=0, push 0xA0,0xA1,0xA2 to ch0. Required:
  - in_ready drops after the second accept, and 0xA2 is held.
  - A word for ch1 (0xB0) is still accepted.
  - After out_ready[0]=1, ch0 delivers 0xA0,0xA1,0xA2 in order; occupancy[ch0] reads 2 at the stall.
- **Simultaneous push/pop:** ch2 holds 1 entry; push to ch2 and pop ch2 in the same cycle. Required: count stays 1 and the order is preserved.
- **Wrap-around:** stream 10 words (0x00..0x09) to ch3 with out_ready[3] toggling every cycle. Required: output sequence 0x00..0x09 exactly, with no loss or duplication.
- **Reset mid-operation:** with all channels partly full, assert rst for 1 cycle. Required: all out_valid=0 next cycle, and the old words never reappear.

Source files
------------

// File: rtl/demux_stream_router.sv
// Buffered 1-to-4 stream router: in_dest steers each word into a per-channel FWFT FIFO.
// Per-channel FIFO first, then the router top that fans the single input stream out to four of them.

// Single-clock first-word-fall-through FIFO, DEPTH entries (power of two).
// Latency: a word written at edge N is at the head in the cycle after N.
// Backpressure: o_wr_full holds off writes; a full FIFO is never written in the cycle it pops.
module demux_stream_router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_vld,
  input  logic [WIDTH-1:0]           i_wr_dat,
  output logic                       o_wr_full,
  input  logic                       i_rd_rdy,
  output logic                       o_rd_vld,
  output logic [WIDTH-1:0]           o_rd_dat,
  output logic [$clog2(DEPTH):0]     o_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_cnt == FULL_CNT);
  assign w_empty = (r_cnt == '0);
  // Full is judged on the pre-edge count, so a pop never makes room for a same-cycle push.
  assign w_push  = i_wr_vld && !w_full && !rst;
  assign w_pop   = i_rd_rdy && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is left uncleared; the output gating below hides stale entries.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wr_dat;
  end

  assign o_wr_full = w_full;
  assign o_rd_vld  = !w_empty;
  assign o_rd_dat  = w_empty ? '0 : r_mem[r_rptr];
  assign o_cnt     = r_cnt;
endmodule

// Router top: one input stream demultiplexed by in_dest into four independent FIFOs.
// Latency: 1 cycle from accept edge to out_valid; no combinational in-to-out path.
// Backpressure: in_ready drops only when the addressed channel is full; other channels keep flowing.
module demux_stream_router #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WIDTH-1:0]                in_data,
  input  logic [1:0]                      in_dest,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [WIDTH-1:0]                out_data0,
  output logic [WIDTH-1:0]                out_data1,
  output logic [WIDTH-1:0]                out_data2,
  output logic [WIDTH-1:0]                out_data3,
  output logic [3:0]                      out_valid,
  input  logic [3:0]                      out_ready,
  output logic [4*($clog2(DEPTH)+1)-1:0]  occupancy
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] w_head [4];
  logic [CW-1:0]    w_cnt  [4];
  logic [3:0]       w_full;
  logic [3:0]       w_push;

  assign in_ready = !rst && !w_full[in_dest];

  for (genvar k = 0; k < 4; k++) begin : g_ch
    assign w_push[k] = in_valid && in_ready && (in_dest == 2'(k));

    demux_stream_router_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr_vld  (w_push[k]),
      .i_wr_dat  (in_data),
      .o_wr_full (w_full[k]),
      .i_rd_rdy  (out_ready[k]),
      .o_rd_vld  (out_valid[k]),
      .o_rd_dat  (w_head[k]),
      .o_cnt     (w_cnt[k])
    );

    assign occupancy[k*CW +: CW] = w_cnt[k];
  end

  assign out_data0 = w_head[0];
  assign out_data1 = w_head[1];
  assign out_data2 = w_head[2];
  assign out_data3 = w_head[3];
endmodule

// File: tb/tb_demux_stream_router.sv
// Scoreboard bench for demux_stream_router (WIDTH=8, DEPTH=2): per-channel expected queues
// are filled on accepted pushes and drained by a monitor on consumer handshakes.
`timescale 1ns/1ps
module tb_demux_stream_router;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_dest;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [4*CW-1:0]  occupancy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] exp_q [4][$];
  int pop_cnt [4];
  logic mon_en = 1'b0;
  logic tog_en = 1'b0;

  demux_stream_router #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] od(input int k);
    case (k)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  function automatic logic [CW-1:0] occ(input int k);
    return occupancy[k*CW +: CW];
  endfunction

  // Monitor: inputs change just after posedge, so at negedge the handshake about to occur is stable.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      for (int k = 0; k < 4; k++) begin
        if (!out_valid[k]) begin
          check($sformatf("ch%0d_idle_data", k), 32'(od(k)), 32'h0);
        end else if (exp_q[k].size() == 0) begin
          check($sformatf("ch%0d_unexpected_valid", k), 32'(out_valid[k]), 32'h0);
        end else if (out_ready[k]) begin
          check($sformatf("ch%0d_data", k), 32'(od(k)), 32'(exp_q[k].pop_front()));
          pop_cnt[k]++;
        end
      end
    end
  end

  // Called just after a posedge; returns just after the edge that accepted the word.
  task automatic send(input logic [WIDTH-1:0] d, input logic [1:0] dst);
    logic acc;
    acc = 1'b0;
    in_data  = d;
    in_dest  = dst;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q[dst].push_back(d);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'(acc), 32'h1);
  endtask

  task automatic drain();
    int left;
    out_ready = 4'hF;
    left = 0;
    for (int t = 0; t < 100; t++) begin
      left = exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
      if (left == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(left), 32'h0);
    @(posedge clk);
    #1;
    check("drain_no_valid", 32'(out_valid), 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dest   = '0;
    out_ready = 4'h0;

    // Reset with random inputs
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      in_dest   = 2'($urandom);
      out_ready = 4'($urandom);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_occupancy", 32'(occupancy), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h0);
      for (int k = 0; k < 4; k++) check($sformatf("rst_data%0d", k), 32'(od(k)), 32'h0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'h0;
    for (int d = 0; d < 4; d++) begin
      in_dest = 2'(d);
      #1;
      check($sformatf("post_rst_in_ready_d%0d", d), 32'(in_ready), 32'h1);
    end
    mon_en = 1'b1;

    // Steering: back-to-back words, consumers always ready
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      logic [WIDTH-1:0] w;
      w = 8'(8'h11 * (i + 1));
      send(w, 2'(i));
      check($sformatf("steer_valid_%0d", i), 32'(out_valid), 32'(4'b1 << i));
      check($sformatf("steer_data_%0d", i), 32'(od(i)), 32'(w));
    end
    drain();

    // Full / backpressure on ch0
    out_ready = 4'h0;
    send(8'hA0, 2'd0);
    send(8'hA1, 2'd0);
    check("bp_occ0_full", 32'(occ(0)), 32'd2);
    in_dest = 2'd0;
    in_valid = 1'b0;
    #1;
    check("bp_in_ready_ch0_full", 32'(in_ready), 32'h0);
    send(8'hB0, 2'd1);
    check("bp_occ1", 32'(occ(1)), 32'd1);
    in_data  = 8'hA2;
    in_dest  = 2'd0;
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_held", 32'(in_ready), 32'h0);
    check("bp_occ0_stall", 32'(occ(0)), 32'd2);
    @(posedge clk);
    #1;
    out_ready = 4'b0011;
    @(negedge clk);
    check("bp_no_passthrough", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    send(8'hA2, 2'd0);
    drain();

    // Simultaneous push/pop on ch2
    out_ready = 4'h0;
    send(8'hC0, 2'd2);
    check("pp_occ2_before", 32'(occ(2)), 32'd1);
    out_ready = 4'b0100;
    send(8'hC1, 2'd2);
    check("pp_occ2_after", 32'(occ(2)), 32'd1);
    check("pp_head", 32'(out_data2), 32'hC1);
    drain();

    // Wrap-around on ch3 with a toggling consumer
    out_ready = 4'h0;
    pop_cnt[3] = 0;
    tog_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) send(8'(i), 2'd3);
        tog_en = 1'b0;
      end
      begin
        while (tog_en) begin
          @(posedge clk);
          #1;
          out_ready[3] = ~out_ready[3];
        end
      end
    join
    drain();
    check("wrap_pop_count", 32'(pop_cnt[3]), 32'd10);

    // Reset mid-operation with every channel holding a word
    out_ready = 4'h0;
    for (int k = 0; k < 4; k++) send(8'hD0 + 8'(k), 2'(k));
    check("mid_occ", 32'(occupancy), 32'h55);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(posedge clk);
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_occ", 32'(occupancy), 32'h0);
    rst = 1'b0;
    out_ready = 4'hF;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check("mid_rst_no_reappear", 32'(out_valid), 32'h0);
    end
    send(8'h5A, 2'd1);
    drain();

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
